i2c_tx_fifo: RTL and testbench

Transmit-data FIFO between the APB register block and the I2C byte engine. It captures each byte the CPU writes to the transmit register (0x02) on the rising edge of the register block's level-type write strobe. It then presents the oldest byte to the I2C core in first-word-fall-through form, popping one byte per core read strobe. It also provides level, full/empty and sticky error flags that the core folds into its status byte.

---
 rtl/i2c_pkg.sv | 24 ++
 rtl/i2c_fifo_ptr.sv | 23 ++
 rtl/i2c_tx_fifo.sv | 89 ++++++++
 tb/tb_i2c_tx_fifo.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// Shared I2C constants: data width, transmit FIFO depth and register map.
package i2c_pkg;

    localparam int unsigned I2C_DW            = 8;
    localparam int unsigned I2C_TX_FIFO_DEPTH = 8;

    // Register addresses decoded by the register block and the core
    typedef enum logic [2:0] {
        I2C_REG_PRESC  = 3'h0,
        I2C_REG_CTRL   = 3'h1,
        I2C_REG_TXR    = 3'h2,
        I2C_REG_RXR    = 3'h3,
        I2C_REG_CMD    = 3'h4,
        I2C_REG_STATUS = 3'h5
    } i2c_reg_e;

    typedef struct packed {
        logic full;
        logic empty;
        logic overflow;
        logic underflow;
    } i2c_tx_flags_t;

endpackage

// File: rtl/i2c_fifo_ptr.sv
// FIFO pointer with one extra wrap bit, increment enable and synchronous clear.
module i2c_fifo_ptr #(
    parameter int unsigned PW = 4
) (
    input  logic          pclk_i,
    input  logic          preset_n_i,
    input  logic          clr_i,
    input  logic          inc_i,
    output logic [PW-1:0] ptr_o
);

    // Clear wins over increment
    always_ff @(posedge pclk_i or negedge preset_n_i) begin
        if (!preset_n_i) begin
            ptr_o <= '0;
        end else if (clr_i) begin
            ptr_o <= '0;
        end else if (inc_i) begin
            ptr_o <= ptr_o + PW'(1);
        end
    end

endmodule

// File: rtl/i2c_tx_fifo.sv
// Transmit FIFO: one push per write-strobe rising edge, FWFT read side, sticky errors.
module i2c_tx_fifo
    import i2c_pkg::*;
#(
    parameter  int unsigned DEPTH = I2C_TX_FIFO_DEPTH,
    parameter  int unsigned DW    = I2C_DW,
    localparam int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          pclk_i,
    input  logic          preset_n_i,
    input  logic          wr_en_i,
    input  logic [DW-1:0] wr_data_i,
    input  logic          rd_en_i,
    input  logic          flush_i,
    output logic [DW-1:0] rd_data_o,
    output logic          empty_o,
    output logic          full_o,
    output logic [AW:0]   count_o,
    output logic          overflow_o,
    output logic          underflow_o
);

    logic          wr_en_q;
    logic          push_req;
    logic          push_acc;
    logic          pop_acc;
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic [DW-1:0] mem [DEPTH];

    assign push_req = wr_en_i & ~wr_en_q;
    assign empty_o  = (wr_ptr == rd_ptr);
    assign full_o   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign count_o  = wr_ptr - rd_ptr;
    assign pop_acc  = rd_en_i & ~empty_o;
    assign push_acc = push_req & (~full_o | pop_acc);

    // Strobe history keeps updating during flush so a strobe rising then is not replayed
    always_ff @(posedge pclk_i or negedge preset_n_i) begin
        if (!preset_n_i) begin
            wr_en_q <= 1'b0;
        end else begin
            wr_en_q <= wr_en_i;
        end
    end

    i2c_fifo_ptr #(.PW(AW + 1)) u_wr_ptr (
        .pclk_i     (pclk_i),
        .preset_n_i (preset_n_i),
        .clr_i      (flush_i),
        .inc_i      (push_acc),
        .ptr_o      (wr_ptr)
    );

    i2c_fifo_ptr #(.PW(AW + 1)) u_rd_ptr (
        .pclk_i     (pclk_i),
        .preset_n_i (preset_n_i),
        .clr_i      (flush_i),
        .inc_i      (pop_acc),
        .ptr_o      (rd_ptr)
    );

    // Storage is not reset; empty masking hides stale entries
    always_ff @(posedge pclk_i) begin
        if (push_acc && !flush_i) begin
            mem[wr_ptr[AW-1:0]] <= wr_data_i;
        end
    end

    assign rd_data_o = empty_o ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge pclk_i or negedge preset_n_i) begin
        if (!preset_n_i) begin
            overflow_o  <= 1'b0;
            underflow_o <= 1'b0;
        end else if (flush_i) begin
            overflow_o  <= 1'b0;
            underflow_o <= 1'b0;
        end else begin
            if (push_req && !push_acc) begin
                overflow_o <= 1'b1;
            end
            if (rd_en_i && empty_o) begin
                underflow_o <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_i2c_tx_fifo.sv
// Scoreboard bench for i2c_tx_fifo: queue model of expected contents and flags.
module tb_i2c_tx_fifo;

    logic       pclk_i;
    logic       preset_n_i;
    logic       wr_en_i;
    logic [7:0] wr_data_i;
    logic       rd_en_i;
    logic       flush_i;
    logic [7:0] rd_data_o;
    logic       empty_o;
    logic       full_o;
    logic [3:0] count_o;
    logic       overflow_o;
    logic       underflow_o;

    int checks = 0;
    int errors = 0;

    logic [7:0] q[$];
    bit         m_prev = 1'b0;
    bit         m_ovf  = 1'b0;
    bit         m_unf  = 1'b0;
    int         n_push = 0;

    i2c_tx_fifo dut (
        .pclk_i      (pclk_i),
        .preset_n_i  (preset_n_i),
        .wr_en_i     (wr_en_i),
        .wr_data_i   (wr_data_i),
        .rd_en_i     (rd_en_i),
        .flush_i     (flush_i),
        .rd_data_o   (rd_data_o),
        .empty_o     (empty_o),
        .full_o      (full_o),
        .count_o     (count_o),
        .overflow_o  (overflow_o),
        .underflow_o (underflow_o)
    );

    initial begin
        pclk_i = 1'b0;
        forever #5 pclk_i = ~pclk_i;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] exp_head();
        return (q.size() > 0) ? q[0] : 8'h00;
    endfunction

    // Drive one cycle, advance the model, sample 1 time unit after the edge
    task automatic drive(input logic wr, input logic [7:0] d, input logic rd, input logic fl);
        bit push_req;
        bit pop_ok;
        bit push_ok;
        wr_en_i   = wr;
        wr_data_i = d;
        rd_en_i   = rd;
        flush_i   = fl;
        push_req  = wr && !m_prev;
        if (fl) begin
            q.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else begin
            pop_ok  = rd && (q.size() > 0);
            if (rd && q.size() == 0) m_unf = 1'b1;
            push_ok = push_req && ((q.size() < 8) || pop_ok);
            if (push_req && !push_ok) m_ovf = 1'b1;
            if (pop_ok) void'(q.pop_front());
            if (push_ok) begin
                q.push_back(d);
                n_push++;
            end
        end
        m_prev = wr;
        @(posedge pclk_i);
        #1;
    endtask

    task automatic push(input logic [7:0] d);
        drive(1'b1, d, 1'b0, 1'b0);
        drive(1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        preset_n_i = 1'b0;
        wr_en_i    = 1'b0;
        wr_data_i  = 8'h00;
        rd_en_i    = 1'b0;
        flush_i    = 1'b0;
        repeat (2) @(posedge pclk_i);
        #1;
        checks++; if (rd_data_o !== 8'h00) begin errors++; $display("FAIL reset_rd_data: got %0h expected 0", rd_data_o); end
        checks++; if (empty_o !== 1'b1) begin errors++; $display("FAIL reset_empty: got %0b expected 1", empty_o); end
        checks++; if (full_o !== 1'b0) begin errors++; $display("FAIL reset_full: got %0b expected 0", full_o); end
        checks++; if (count_o !== 4'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", count_o); end
        checks++; if (overflow_o !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %0b expected 0", overflow_o); end
        checks++; if (underflow_o !== 1'b0) begin errors++; $display("FAIL reset_underflow: got %0b expected 0", underflow_o); end
        preset_n_i = 1'b1;
    endtask

    task automatic test_full_overflow();
        for (int i = 1; i <= 8; i++) push(8'(i));
        push(8'hFF);
        checks++; if (full_o !== 1'b1) begin errors++; $display("FAIL full_flag: got %0b expected 1", full_o); end
        checks++; if (count_o !== 4'd8) begin errors++; $display("FAIL full_count: got %0d expected 8", count_o); end
        checks++; if (overflow_o !== 1'b1) begin errors++; $display("FAIL overflow_set: got %0b expected 1", overflow_o); end
        for (int i = 1; i <= 8; i++) begin
            checks++; if (rd_data_o !== 8'(i)) begin errors++; $display("FAIL drain_order[%0d]: got %0h expected %0h", i, rd_data_o, 8'(i)); end
            drive(1'b0, 8'h00, 1'b1, 1'b0);
        end
        checks++; if (empty_o !== 1'b1) begin errors++; $display("FAIL drained_empty: got %0b expected 1", empty_o); end
        checks++; if (rd_data_o !== 8'h00) begin errors++; $display("FAIL drained_rd_data: got %0h expected 0", rd_data_o); end
        checks++; if (overflow_o !== 1'b1) begin errors++; $display("FAIL overflow_sticky: got %0b expected 1", overflow_o); end
        drive(1'b0, 8'h00, 1'b0, 1'b1);
        checks++; if (overflow_o !== 1'b0) begin errors++; $display("FAIL overflow_flush_clear: got %0b expected 0", overflow_o); end
    endtask

    task automatic test_long_strobe();
        drive(1'b1, 8'hA5, 1'b0, 1'b0);
        checks++; if (count_o !== 4'd1) begin errors++; $display("FAIL strobe_count: got %0d expected 1", count_o); end
        checks++; if (rd_data_o !== 8'hA5) begin errors++; $display("FAIL strobe_head: got %0h expected a5", rd_data_o); end
        checks++; if (empty_o !== 1'b0) begin errors++; $display("FAIL strobe_empty: got %0b expected 0", empty_o); end
        drive(1'b1, 8'hA5, 1'b0, 1'b0);
        drive(1'b1, 8'hA5, 1'b0, 1'b0);
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        checks++; if (count_o !== 4'd1) begin errors++; $display("FAIL strobe_single_push: got %0d expected 1", count_o); end
        checks++; if (rd_data_o !== exp_head()) begin errors++; $display("FAIL strobe_pop_data: got %0h expected %0h", rd_data_o, exp_head()); end
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        checks++; if (empty_o !== 1'b1) begin errors++; $display("FAIL strobe_drained: got %0b expected 1", empty_o); end
    endtask

    task automatic test_full_pushpop();
        logic [7:0] last;
        last = 8'h00;
        for (int i = 1; i <= 8; i++) push(8'(i));
        checks++; if (rd_data_o !== 8'h01) begin errors++; $display("FAIL pushpop_head: got %0h expected 01", rd_data_o); end
        drive(1'b1, 8'h55, 1'b1, 1'b0);
        checks++; if (count_o !== 4'd8) begin errors++; $display("FAIL pushpop_count: got %0d expected 8", count_o); end
        checks++; if (overflow_o !== 1'b0) begin errors++; $display("FAIL pushpop_no_overflow: got %0b expected 0", overflow_o); end
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        while (q.size() > 0) begin
            last = q[0];
            checks++; if (rd_data_o !== q[0]) begin errors++; $display("FAIL pushpop_drain: got %0h expected %0h", rd_data_o, q[0]); end
            drive(1'b0, 8'h00, 1'b1, 1'b0);
        end
        checks++; if (last !== 8'h55) begin errors++; $display("FAIL pushpop_last: got %0h expected 55", last); end
        checks++; if (empty_o !== 1'b1) begin errors++; $display("FAIL pushpop_empty: got %0b expected 1", empty_o); end
    endtask

    task automatic test_underflow();
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        checks++; if (underflow_o !== 1'b1) begin errors++; $display("FAIL underflow_set: got %0b expected 1", underflow_o); end
        checks++; if (count_o !== 4'd0) begin errors++; $display("FAIL underflow_count: got %0d expected 0", count_o); end
        drive(1'b1, 8'h3C, 1'b1, 1'b0);
        checks++; if (count_o !== 4'd1) begin errors++; $display("FAIL empty_pushpop_count: got %0d expected 1", count_o); end
        checks++; if (rd_data_o !== 8'h3C) begin errors++; $display("FAIL empty_pushpop_head: got %0h expected 3c", rd_data_o); end
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        checks++; if (empty_o !== 1'b1) begin errors++; $display("FAIL underflow_drain: got %0b expected 1", empty_o); end
    endtask

    task automatic test_wrap();
        int         start;
        int         pushed;
        logic       wr;
        logic       rd;
        logic [7:0] d;
        for (int i = 0; i < 2; i++) begin
            push(8'h90 + 8'(i));
            drive(1'b0, 8'h00, 1'b1, 1'b0);
        end
        start  = n_push;
        pushed = 0;
        wr     = 1'b0;
        for (int c = 0; c < 200 && (pushed < 12 || q.size() > 0); c++) begin
            wr = (pushed < 12) ? ~wr : 1'b0;
            d  = 8'($urandom);
            rd = (q.size() > 0) && ($urandom_range(0, 2) != 0);
            if (rd) begin
                checks++; if (rd_data_o !== q[0]) begin errors++; $display("FAIL wrap_order: got %0h expected %0h", rd_data_o, q[0]); end
            end
            drive(wr, d, rd, 1'b0);
            checks++; if (count_o !== 4'(q.size())) begin errors++; $display("FAIL wrap_count: got %0d expected %0d", count_o, q.size()); end
            pushed = n_push - start;
        end
        checks++; if (pushed != 12 || q.size() != 0) begin errors++; $display("FAIL wrap_done: pushed %0d left %0d required 12 and 0", pushed, q.size()); end
    endtask

    task automatic test_flush();
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) push(8'hC0 + 8'(i));
        checks++; if (count_o !== 4'd5) begin errors++; $display("FAIL flush_preload: got %0d expected 5", count_o); end
        drive(1'b1, 8'hEE, 1'b0, 1'b1);
        checks++; if (count_o !== 4'd0) begin errors++; $display("FAIL flush_count: got %0d expected 0", count_o); end
        checks++; if (empty_o !== 1'b1) begin errors++; $display("FAIL flush_empty: got %0b expected 1", empty_o); end
        checks++; if (underflow_o !== 1'b0) begin errors++; $display("FAIL flush_underflow: got %0b expected 0", underflow_o); end
        checks++; if (rd_data_o !== 8'h00) begin errors++; $display("FAIL flush_rd_data: got %0h expected 0", rd_data_o); end
        drive(1'b1, 8'hEE, 1'b0, 1'b0);
        checks++; if (count_o !== 4'd0) begin errors++; $display("FAIL flush_strobe_dropped: got %0d expected 0", count_o); end
        drive(1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) push(8'h20 + 8'(i));
        #3;
        preset_n_i = 1'b0;
        wr_en_i    = 1'b1;
        wr_data_i  = 8'h77;
        q.delete();
        m_prev = 1'b0;
        m_ovf  = 1'b0;
        m_unf  = 1'b0;
        #1;
        checks++; if (count_o !== 4'd0) begin errors++; $display("FAIL midreset_count: got %0d expected 0", count_o); end
        checks++; if (empty_o !== 1'b1) begin errors++; $display("FAIL midreset_empty: got %0b expected 1", empty_o); end
        checks++; if (rd_data_o !== 8'h00) begin errors++; $display("FAIL midreset_rd_data: got %0h expected 0", rd_data_o); end
        checks++; if (full_o !== 1'b0 || overflow_o !== 1'b0 || underflow_o !== 1'b0) begin
            errors++; $display("FAIL midreset_flags: got full %0b ovf %0b unf %0b expected 0 0 0", full_o, overflow_o, underflow_o);
        end
        @(posedge pclk_i);
        #1;
        preset_n_i = 1'b1;
        drive(1'b1, 8'h77, 1'b0, 1'b0);
        checks++; if (count_o !== 4'd1) begin errors++; $display("FAIL release_push_count: got %0d expected 1", count_o); end
        checks++; if (rd_data_o !== 8'h77) begin errors++; $display("FAIL release_push_head: got %0h expected 77", rd_data_o); end
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        checks++; if (empty_o !== 1'b1) begin errors++; $display("FAIL release_drain: got %0b expected 1", empty_o); end
    endtask

    initial begin
        test_reset();
        test_full_overflow();
        test_long_strobe();
        test_full_pushpop();
        test_underflow();
        test_wrap();
        test_flush();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
